// File: rtl/slice_stream.sv
// slice_stream: pipelined multi-channel bit-field extractor.
//
// Each of NUM_CHANNELS packed input words yields an OUTPUT_DATA_WIDTH-bit
// field. The field position is a runtime offset. A newly loaded offset is
// held pending and only takes effect on the next qualified frame sync, so
// every channel switches on the same sample.
//
// Optional feature: define SLICE_STREAM_ROUND_EN to round half-up, with
// saturation, in stage 2. Left undefined, the field is truncated.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   data_in         NUM_CHANNELS packed unsigned words, channel k at [k*IW +: IW]
//   data_in_valid   qualifies data_in and sync_in
//   sync_in         frame marker, one cycle wide
//   offset_in       requested offset, captured by offset_load
//   offset_load     one-cycle load strobe
//   data_out        NUM_CHANNELS packed fields, channel k at [k*OW +: OW]
//   data_out_valid  data_in_valid delayed by LATENCY
//   sync_out        sync_in & data_in_valid delayed by LATENCY
//   offset_active   offset applied at stage 1
//   offset_pending  a loaded offset is waiting for sync
//   offset_err      one-cycle pulse when a loaded offset was clamped

// Per-channel extractor. It holds stage 1, which selects the field. With
// rounding enabled it also holds stage 2, which rounds and saturates.
module slice_stream_lane #(
  parameter int IW      = 8,
  parameter int OW      = 4,
  parameter int OFW     = 3,
  parameter int MSB_REL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  din,
  input  logic [OFW-1:0] off,
  output logic [OW-1:0]  fld
);
  // b is the input bit position of the field LSB. The offset is already
  // clamped, so the MSB-relative subtraction cannot underflow.
  logic [OFW-1:0] b;
  always_comb b = (MSB_REL != 0) ? OFW'(IW - OW) - off : off;

`ifdef SLICE_STREAM_ROUND_EN
  // Append a zero below the LSB so a single shift yields both the field
  // and the round bit din[b-1]. The round bit becomes 0 when b == 0.
  logic [OW:0]   ext;
  logic [OW-1:0] f1;
  logic          r1;
  always_comb ext = (OW+1)'({din, 1'b0} >> b);

  always_ff @(posedge clk) begin
    if (rst) begin
      f1 <= '0;
      r1 <= 1'b0;
    end else begin
      f1 <= ext[OW:1];
      r1 <= ext[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    fld <= '0;
    else if (r1 && (f1 != '1))  fld <= f1 + 1'b1;
    else                        fld <= f1;  // saturate rather than wrap
  end
`else
  always_ff @(posedge clk) begin
    if (rst) fld <= '0;
    else     fld <= OW'(din >> b);
  end
`endif
endmodule

module slice_stream #(
  parameter string ARCHITECTURE      = "BEHAVIORAL",
  parameter int    INPUT_DATA_WIDTH  = 8,
  parameter int    OUTPUT_DATA_WIDTH = 4,
  parameter int    NUM_CHANNELS      = 2,
  parameter int    OFFSET_REL_TO_MSB = 1,
  parameter int    DEFAULT_OFFSET    = 0,
  parameter int    OFFSET_WIDTH      = 3,
  parameter int    LATENCY           = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_CHANNELS*INPUT_DATA_WIDTH-1:0]  data_in,
  input  logic                                    data_in_valid,
  input  logic                                    sync_in,
  input  logic [OFFSET_WIDTH-1:0]                 offset_in,
  input  logic                                    offset_load,
  output logic [NUM_CHANNELS*OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                                    data_out_valid,
  output logic                                    sync_out,
  output logic [OFFSET_WIDTH-1:0]                 offset_active,
  output logic                                    offset_pending,
  output logic                                    offset_err
);
  localparam int IW      = INPUT_DATA_WIDTH;
  localparam int OW      = OUTPUT_DATA_WIDTH;
  localparam int NC      = NUM_CHANNELS;
  localparam int OFW     = OFFSET_WIDTH;
  localparam int MAX_OFF = IW - OW;
  localparam int DEF_OFF = (DEFAULT_OFFSET > MAX_OFF) ? MAX_OFF : DEFAULT_OFFSET;
`ifdef SLICE_STREAM_ROUND_EN
  localparam int LANE_LAT = 2;
`else
  localparam int LANE_LAT = 1;
`endif
  localparam int DLY = LATENCY - LANE_LAT;

  typedef enum logic {ST_ACTIVE, ST_PENDING} state_t;

  if (ARCHITECTURE == "BEHAVIORAL") begin : g_beh
    state_t         state;
    logic [OFW-1:0] act_off, pend_off, use_off, load_val;
    logic           err, qsync, apply;
    logic [LATENCY:1] vld_pipe, syn_pipe;
    logic [NC-1:0][OW-1:0] lane_fld;

    always_comb begin
      qsync    = sync_in & data_in_valid;
      apply    = qsync & (state == ST_PENDING);
      // The sync sample itself must already see the new offset.
      use_off  = apply ? pend_off : act_off;
      load_val = (offset_in > OFW'(MAX_OFF)) ? OFW'(MAX_OFF) : offset_in;
    end

    // A load that coincides with an applying sync replaces the pending
    // value after the old one moves to active, so it waits for the next sync.
    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= ST_ACTIVE;
        act_off  <= OFW'(DEF_OFF);
        pend_off <= '0;
        err      <= 1'b0;
      end else begin
        err <= offset_load && (offset_in > OFW'(MAX_OFF));
        if (apply) act_off <= pend_off;
        if (offset_load) begin
          pend_off <= load_val;
          state    <= ST_PENDING;
        end else if (apply) begin
          state    <= ST_ACTIVE;
        end
      end
    end

    for (genvar k = 0; k < NC; k++) begin : g_lane
      slice_stream_lane #(.IW(IW), .OW(OW), .OFW(OFW), .MSB_REL(OFFSET_REL_TO_MSB)) u_lane (
        .clk (clk),
        .rst (rst),
        .din (data_in[k*IW +: IW]),
        .off (use_off),
        .fld (lane_fld[k])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
        syn_pipe <= '0;
      end else begin
        vld_pipe[1] <= data_in_valid;
        syn_pipe[1] <= qsync;
        for (int i = 2; i <= LATENCY; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          syn_pipe[i] <= syn_pipe[i-1];
        end
      end
    end

    if (DLY > 0) begin : g_dly
      logic [DLY:1][NC*OW-1:0] dly_pipe;
      always_ff @(posedge clk) begin
        if (rst) dly_pipe <= '0;
        else begin
          dly_pipe[1] <= lane_fld;
          for (int i = 2; i <= DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
        end
      end
      assign data_out = dly_pipe[DLY];
    end else begin : g_nodly
      assign data_out = lane_fld;
    end

    assign data_out_valid = vld_pipe[LATENCY];
    assign sync_out       = syn_pipe[LATENCY];
    assign offset_active  = act_off;
    assign offset_pending = (state == ST_PENDING);
    assign offset_err     = err;
  end else begin : g_stub
    // Vendor-specific architectures are placeholders with no logic.
    assign data_out       = '0;
    assign data_out_valid = 1'b0;
    assign sync_out       = 1'b0;
    assign offset_active  = '0;
    assign offset_pending = 1'b0;
    assign offset_err     = 1'b0;
  end
endmodule

// File: tb/tb_slice_stream.sv
module tb_slice_stream;
  localparam int IW = 8, OW = 4, NC = 2, OFW = 3, LAT = 2, MAXO = IW - OW;

  logic clk = 1'b0;
  logic rst;
  logic [NC*IW-1:0] data_in;
  logic data_in_valid, sync_in, offset_load;
  logic [OFW-1:0] offset_in;
  logic [NC*OW-1:0] data_out;
  logic data_out_valid, sync_out, offset_pending, offset_err;
  logic [OFW-1:0] offset_active;

  slice_stream #(
    .ARCHITECTURE("BEHAVIORAL"), .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW),
    .NUM_CHANNELS(NC), .OFFSET_REL_TO_MSB(1), .DEFAULT_OFFSET(0),
    .OFFSET_WIDTH(OFW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .sync_in(sync_in), .offset_in(offset_in), .offset_load(offset_load),
    .data_out(data_out), .data_out_valid(data_out_valid), .sync_out(sync_out),
    .offset_active(offset_active), .offset_pending(offset_pending),
    .offset_err(offset_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct packed { logic [NC*OW-1:0] d; logic v; logic s; } exp_t;
  exp_t q[$];
  int m_act = 0, m_pend = 0, m_pval = 0, m_err = 0;

  // Reference field: MSB-relative offset drops 'off' bits from the top.
  function automatic int fld(int x, int off);
    int b, f;
    b = IW - OW - off;
    f = (x >> b) & ((1 << OW) - 1);
`ifdef SLICE_STREAM_ROUND_EN
    if (b > 0 && ((x >> (b - 1)) & 1) == 1) f = (f == (1 << OW) - 1) ? f : f + 1;
`endif
    return f;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // One clock of stimulus. The model predicts this sample's output and the
  // offset state, and then the outputs are compared #1 after the edge.
  task automatic step(int d, bit v, bit s, bit ld, int off, bit r);
    exp_t e;
    int eo, ed;
    data_in = d[NC*IW-1:0]; data_in_valid = v; sync_in = s;
    offset_load = ld; offset_in = off[OFW-1:0]; rst = r;
    if (r) begin
      m_act = 0; m_pend = 0; m_err = 0;
      q.delete();
    end else begin
      eo = (s && v && m_pend != 0) ? m_pval : m_act;
      ed = 0;
      for (int k = 0; k < NC; k++) ed |= fld((d >> (k*IW)) & ((1 << IW) - 1), eo) << (k*OW);
      e.d = ed[NC*OW-1:0]; e.v = v; e.s = s && v;
      q.push_back(e);
      if (s && v && m_pend != 0) begin m_act = m_pval; m_pend = 0; end
      m_err = (ld && off > MAXO) ? 1 : 0;
      if (ld) begin m_pval = (off > MAXO) ? MAXO : off; m_pend = 1; end
    end
    @(posedge clk); #1;
    if (r) begin
      e = '0;
      repeat (LAT - 1) q.push_back('0);
    end else begin
      e = q.pop_front();
    end
    chk("data_out", data_out, e.d);
    chk("data_out_valid", data_out_valid, e.v);
    chk("sync_out", sync_out, e.s);
    chk("offset_active", offset_active, m_act);
    chk("offset_pending", offset_pending, m_pend);
    chk("offset_err", offset_err, m_err);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int d, off;
    bit v, s, ld, r;
    rst = 1'b1; data_in = '0; data_in_valid = 0; sync_in = 0;
    offset_load = 0; offset_in = '0;

    // Pin the reference field function with hand-derived values.
    chk("mdl_b6_off0", fld(8'hB6, 0), 4'hB);
`ifdef SLICE_STREAM_ROUND_EN
    chk("mdl_b6_off2", fld(8'hB6, 2), 4'hE);
`else
    chk("mdl_b6_off2", fld(8'hB6, 2), 4'hD);
`endif
    chk("mdl_b6_off4", fld(8'hB6, 4), 4'h6);
    chk("mdl_3e_off2", fld(8'h3E, 2), 4'hF);

    step(0, 0, 0, 0, 0, 1);
    chk("rst_active", offset_active, 0);
    chk("rst_data", data_out, 0);

    // Default offset 0.
    step(16'hB6B6, 1, 0, 0, 0, 0);
    idle();
    chk("first_out", data_out, 8'hBB);
    chk("first_valid", data_out_valid, 1);

    // Load offset 2. Samples before the sync keep the old offset.
    step(16'hB6B6, 1, 0, 1, 2, 0);
    chk("load2_pending", offset_pending, 1);
    step(16'hB6B6, 1, 1, 0, 0, 0);
    chk("presync_out", data_out, 8'hBB);
    chk("sync_active2", offset_active, 2);
    idle();
`ifdef SLICE_STREAM_ROUND_EN
    chk("off2_out", data_out, 8'hEE);
`else
    chk("off2_out", data_out, 8'hDD);
`endif
    chk("off2_sync_out", sync_out, 1);

    // Clamped load.
    step(0, 0, 0, 1, 6, 0);
    chk("clamp_err", offset_err, 1);
    idle();
    chk("clamp_err_clear", offset_err, 0);
    step(16'hB6B6, 1, 1, 0, 0, 0);
    chk("clamp_active", offset_active, 4);
    idle();
    chk("off4_out", data_out, 8'h66);

    // Overwriting the pending value.
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 3, 0);
    step(16'hB6B6, 1, 1, 0, 0, 0);
    chk("overwrite_active", offset_active, 3);

    // A load coinciding with a sync waits for the following sync.
    step(0, 0, 0, 1, 1, 0);
    step(16'hB6B6, 1, 1, 1, 2, 0);
    chk("coinc_active", offset_active, 1);
    chk("coinc_pending", offset_pending, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("coinc_next_active", offset_active, 2);

    // Rounding must saturate rather than wrap.
    step(16'h3E3E, 1, 1, 0, 0, 0);
    idle();
    chk("sat_out", data_out, 8'hFF);

    // Reset while pending, with samples in flight.
    step(0, 0, 0, 1, 3, 0);
    step(16'hB6B6, 1, 1, 0, 0, 0);
    step(16'hB6B6, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_mid_pending", offset_pending, 0);
    chk("rst_mid_active", offset_active, 0);
    chk("rst_mid_valid", data_out_valid, 0);
    idle();
    chk("rst_mid_stale", data_out_valid, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      d   = int'($urandom_range(0, 16'hFFFF));
      v   = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 9) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      off = int'($urandom_range(0, 7));
      r   = ($urandom_range(0, 199) == 0);
      step(d, v, s, ld, off, r);
    end
    repeat (LAT + 1) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
